operand_feeder: RTL and testbench

Operand buffer that sits directly upstream of the multiply-and-shift stage. It accepts 8-bit operands from a producer over a valid/ready handshake, queues them in a small FIFO, and presents the head operand on `d`. It pops one entry each time the multiplier asserts `input_grant`. It decouples bursty producers from the multiplier's fixed multi-cycle sequence and flags grants that arrive while the queue is empty.

---
 rtl/operand_feeder.sv | 88 ++++++++
 tb/tb_operand_feeder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/operand_feeder.sv
// rtl/operand_feeder.sv - operand FIFO feeding the multiply-and-shift stage
// Optional grant-underrun counter built when OPERAND_FEEDER_UNDERRUN_EN is defined.
module operand_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     input_grant,
  output logic [WIDTH-1:0]         d,
  output logic                     d_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] last_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  // Ready comes only from occupancy, so a grant never opens a slot in the same cycle.
  assign push     = in_valid && !full;
  assign pop      = input_grant && !empty;

  assign in_ready = !full;
  assign d_valid  = !empty;
  assign count    = count_q;
  assign d        = empty ? last_q : mem[rd_ptr];

  // Storage is left unreset; d never exposes it while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

`ifdef OPERAND_FEEDER_UNDERRUN_EN
  logic [7:0] underrun_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_q <= '0;
    end else if (input_grant && empty && (underrun_q != 8'hFF)) begin
      underrun_q <= underrun_q + 8'd1;
    end
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_operand_feeder.sv
// tb/tb_operand_feeder.sv - randomized and directed check of operand_feeder against a queue model
module tb_operand_feeder;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             input_grant;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [2:0]       count;
  logic [7:0]       underrun_cnt;

  int checks = 0;
  int errors = 0;

  operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .input_grant(input_grant), .d(d), .d_valid(d_valid), .count(count),
    .underrun_cnt(underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue, the last popped value, and the underrun tally.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_last = '0;
  int               m_und = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_last = '0;
      m_und  = 0;
    end else begin
      automatic int  sz = mq.size();
      automatic bit  do_push = in_valid && (sz < DEPTH);
      automatic bit  do_pop  = input_grant && (sz > 0);
      if (input_grant && sz == 0 && m_und < 255) m_und = m_und + 1;
      if (do_pop) m_last = mq.pop_front();
      if (do_push) mq.push_back(in_data);
    end
  end

  function automatic int exp_und();
`ifdef OPERAND_FEEDER_UNDERRUN_EN
    return m_und;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("model_d", 32'(d), 32'((mq.size() > 0) ? mq[0] : m_last));
      chk("model_d_valid", 32'(d_valid), 32'(mq.size() > 0));
      chk("model_count", 32'(count), 32'(mq.size()));
      chk("model_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("model_underrun", 32'(underrun_cnt), 32'(exp_und()));
    end
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] dat, input logic g);
    in_valid    = v;
    in_data     = dat;
    input_grant = g;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [7:0] seq [4];
    logic [7:0] seq2 [4];
    seq  = '{8'd3, 8'd11, 8'd20, 8'd7};
    seq2 = '{8'd2, 8'd3, 8'd4, 8'd5};
    rst = 1'b0; in_valid = 1'b0; in_data = '0; input_grant = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_d", 32'(d), 0);
    chk("reset_d_valid", 32'(d_valid), 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_underrun", 32'(underrun_cnt), 0);
    @(negedge clk);

    // single operand
    step(1'b1, 8'd10, 1'b0);
    idle(1);
    chk("single_d", 32'(d), 10);
    chk("single_d_valid", 32'(d_valid), 1);
    step(1'b0, '0, 1'b1);
    chk("single_count_after", 32'(count), 0);
    chk("single_d_valid_after", 32'(d_valid), 0);
    chk("single_d_after", 32'(d), 10);

    // fill and drain
    for (int i = 0; i < 4; i++) step(1'b1, seq[i], 1'b0);
    chk("fill_count", 32'(count), 4);
    chk("fill_in_ready", 32'(in_ready), 0);
    step(1'b1, 8'd99, 1'b0);
    chk("fill_refused_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_d", 32'(d), 32'(seq[i]));
      step(1'b0, '0, 1'b1);
      idle(3);
    end
    chk("drain_count", 32'(count), 0);

    // underrun with last_q = 7
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    chk("underrun_d", 32'(d), 7);
`ifdef OPERAND_FEEDER_UNDERRUN_EN
    chk("underrun_3", 32'(underrun_cnt), 3);
`else
    chk("underrun_3", 32'(underrun_cnt), 0);
`endif

    // full with push and pop together
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i + 1), 1'b0);
    step(1'b1, 8'd5, 1'b1);
    chk("full_pushpop_count", 32'(count), 3);
    step(1'b1, 8'd5, 1'b0);
    chk("full_retry_count", 32'(count), 4);
    for (int i = 0; i < 4; i++) begin
      chk("full_tail_d", 32'(d), 32'(seq2[i]));
      step(1'b0, '0, 1'b1);
    end

    // empty with push and pop together
    step(1'b1, 8'd42, 1'b1);
    chk("empty_pushpop_d", 32'(d), 42);
    chk("empty_pushpop_count", 32'(count), 1);
    step(1'b0, '0, 1'b1);

    // saturation
    for (int i = 0; i < 300; i++) step(1'b0, '0, 1'b1);
`ifdef OPERAND_FEEDER_UNDERRUN_EN
    chk("underrun_sat", 32'(underrun_cnt), 255);
`else
    chk("underrun_sat", 32'(underrun_cnt), 0);
`endif

    // async reset mid-stream
    step(1'b1, 8'd17, 1'b0);
    step(1'b1, 8'd18, 1'b0);
    step(1'b0, '0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("areset_d", 32'(d), 0);
    chk("areset_d_valid", 32'(d_valid), 0);
    chk("areset_count", 32'(count), 0);
    chk("areset_in_ready", 32'(in_ready), 1);
    chk("areset_underrun", 32'(underrun_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'd2, 1'b0);
    chk("post_reset_d", 32'(d), 2);
    chk("post_reset_d_valid", 32'(d_valid), 1);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
